pmod_keypad_scan: RTL and testbench
===================================

Name: pmod_keypad_scan

Overview:
- Scanner for a 4x4 multiplexed keypad (Digilent Pmod KYPD) on a Nexys A7 Pmod header. It is the input-side counterpart of the board's multiplexed seven-segment driver.
- Strobes one column low at a time and samples the rows. Debounces whole scan frames.
- Presents single-key press events as a 4-bit hex code on a valid/ready interface. Runs in clk_core, so a GPIO or wishbone wrapper can feed key codes to the SweRV core.

Parameters:
- SCAN_DIV, 50000, clk cycles each column is driven; the rows are sampled on the last of them. Must be >= 4.
- DEBOUNCE_FRAMES, 4, number of consecutive identical raw frames required before the stable key map updates. Must be >= 2.

Ports:
- i_clk  in  1  core clock
- i_rst  in  1  reset; asynchronous, active-high
- o_col  out  4  column strobes, active-low, one-hot-low while scanning
- i_row  in  4  row returns, active-low, pulled up externally, asynchronous to i_clk
- o_key_code  out  4  hex code of the pressed key
- o_key_valid  out  1  press event pending
- i_key_ready  in  1  consumer accepts the event
- o_pressed  out  1  stable map has exactly one key down
- o_multi  out  1  stable map has two or more keys down
- o_overrun  out  1  sticky flag: an event was lost
- i_clr_overrun  in  1  clears o_overrun

Behaviour:
- Reset: o_col=4'hF, o_key_code=0, o_key_valid=0, o_pressed=0, o_multi=0, o_overrun=0. Internal state: column index 0, divider 0, raw/previous/stable maps 0, match count 0.
- Reset mid-scan or mid-debounce discards all partial state. A key held across reset yields a fresh event after DEBOUNCE_FRAMES full frames.
- i_row passes through a 2-flop synchronizer. This is why SCAN_DIV >= 4 is required: 2 cycles of sync plus settle.
- Scan FSM states: COL0, COL1, COL2, COL3. On entry to COLc, o_col drives bit c low and all others high. The first column drive appears 1 cycle after reset release.
- Divider counts 0..SCAN_DIV-1. At SCAN_DIV-1, the synchronized ~row is stored into raw[4c+3:4c] and the FSM advances (COL3 wraps to COL0).
- A frame is 4*SCAN_DIV cycles. The frame completes on the COL3 sample cycle.
- Key map bit index = 4*col + row. Codes per column:
  - col0 rows 0-3: 1,4,7,0
  - col1: 2,5,8,F
  - col2: 3,6,9,E
  - col3: A,B,C,D
- Debounce at frame end:
  - If raw equals the previous frame, the match count increments, saturating at DEBOUNCE_FRAMES-1.
  - Otherwise the match count goes to 0.
  - When the count reaches DEBOUNCE_FRAMES-1, stable takes raw.
- o_pressed = (popcount(stable)==1); o_multi = (popcount(stable)>=2). Both are registered and update the cycle after stable changes.
- Press event: generated when stable goes from all-zero to exactly one bit set.
  - No event for multi-key maps.
  - No event when going from one key straight to a different single key without passing through all-released (no rollover).
- Event output: o_key_code loads the code and o_key_valid rises 1 cycle after the stable update.
- Handshake: o_key_valid stays high with o_key_code frozen until a cycle with i_key_ready=1; it drops the next cycle.
  - i_key_ready while o_key_valid=0 has no effect.
- New event while o_key_valid=1 and i_key_ready=0 in the same cycle: the new event is dropped, o_key_code keeps its old value, and o_overrun sets.
- New event in the same cycle as an accepting i_key_ready: the new event loads and o_key_valid stays 1 (no bubble).
- o_overrun clears on i_clr_overrun. If a set and a clear occur in the same cycle, set wins.

Decomposition:
- Package kypd_pkg holds:
  - the scan state enum (COL0..COL3)
  - a 16-entry localparam array mapping key index to hex code
  - the localparam NUM_COLS=4
- One natural sub-module: kypd_debounce. It takes the 16-bit raw frame plus a frame_done strobe and outputs the stable map, the match counter and the new-press strobe.
- Scan FSM, synchronizer and event register stay in the top.

Test Plan (SCAN_DIV=8, DEBOUNCE_FRAMES=3; frame = 32 cycles):
- Idle after reset: o_col cycles E,D,B,7, changing every 8 cycles. o_key_valid stays 0 for 20 frames and o_pressed=0.
- Hold key "5" (col1,row1) from cycle 0: o_key_valid=1 with o_key_code=4'h5 by the end of frame 4 (+1 cycle). o_pressed=1. Ready pulse drops valid next cycle. Holding on produces no further events.
- Bounce "9" (row toggles every 40 cycles for 5 frames, then steady): no event during bouncing; exactly one event, code 9, 3 frames after it settles.
- Press "1" and "D" together: o_multi=1, o_pressed=0, no event. Release all, then press "E": event code E.
- Press/release "A", then "3" with i_key_ready=0: first event stays at A and o_overrun=1. i_clr_overrun clears the flag; when ready rises, code A is delivered.
- Assert i_rst mid-frame while "0" is held: outputs return to reset values immediately (asynchronously). After release, an event with code 0 occurs after 3 full frames.

Source files
------------

// File: rtl/kypd_pkg.sv
// Shared types, constants and helpers for the Pmod KYPD 4x4 keypad scanner.
package kypd_pkg;

  localparam int unsigned NUM_COLS = 4;

  // Scan state: which column is currently strobed low.
  typedef enum logic [1:0] {COL0, COL1, COL2, COL3} scan_state_e;

  // Key map bit index (4*col + row) to the hex legend printed on the keypad.
  localparam logic [3:0] KEY_CODE [16] = '{
    4'h1, 4'h4, 4'h7, 4'h0,
    4'h2, 4'h5, 4'h8, 4'hF,
    4'h3, 4'h6, 4'h9, 4'hE,
    4'hA, 4'hB, 4'hC, 4'hD
  };

  function automatic logic [4:0] popcount16(input logic [15:0] map);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + 5'(map[i]);
    end
    return cnt;
  endfunction

  // Index of the lowest set bit; only meaningful when exactly one bit is set.
  function automatic logic [3:0] lowest_index(input logic [15:0] map);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (map[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/pmod_keypad_scan_if.sv
// Key event valid/ready channel between the scanner and its consumer.
interface pmod_keypad_scan_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;

  modport master (output key_code, output key_valid, input key_ready);
  modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/kypd_debounce.sv
// Frame-level debouncer: the stable key map only changes after the same raw
// frame has been seen DEBOUNCE_FRAMES times in a row.
module kypd_debounce
  import kypd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 4,
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_FRAMES)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [15:0]      i_raw,
  input  logic             i_frame_done,
  output logic [15:0]      o_stable,
  output logic [CNT_W-1:0] o_match_cnt,
  output logic             o_new_press
);

  localparam logic [CNT_W-1:0] LAST_MATCH = CNT_W'(DEBOUNCE_FRAMES - 1);

  logic [15:0]      prev_q;
  logic [15:0]      stable_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             new_press_q;
  logic             take_raw;

  // Next match count: saturating run length of identical frames.
  always_comb begin
    cnt_d = cnt_q;
    if (i_frame_done) begin
      if (i_raw == prev_q) begin
        cnt_d = (cnt_q == LAST_MATCH) ? cnt_q : cnt_q + 1'b1;
      end else begin
        cnt_d = '0;
      end
    end
  end

  assign take_raw = i_frame_done && (cnt_d == LAST_MATCH);

  // Frame history, stable map and the single-key press strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prev_q      <= '0;
      stable_q    <= '0;
      cnt_q       <= '0;
      new_press_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      new_press_q <= take_raw && (stable_q == '0) && (popcount16(i_raw) == 5'd1);
      if (i_frame_done) begin
        prev_q <= i_raw;
      end
      if (take_raw) begin
        stable_q <= i_raw;
      end
    end
  end

  assign o_stable    = stable_q;
  assign o_match_cnt = cnt_q;
  assign o_new_press = new_press_q;

endmodule

// File: rtl/pmod_keypad_scan.sv
// Pmod KYPD scanner: strobes columns low one at a time, samples the rows,
// debounces whole frames and emits single-key press events on a valid/ready
// channel.
module pmod_keypad_scan
  import kypd_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 50000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  output logic [NUM_COLS-1:0]       o_col,
  input  logic [3:0]                i_row,
  pmod_keypad_scan_if.master        kbd,
  output logic                      o_pressed,
  output logic                      o_multi,
  output logic                      o_overrun,
  input  logic                      i_clr_overrun
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_FRAMES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_FRAMES - 1);

  scan_state_e        state_q;
  logic [DIV_W-1:0]   div_q;
  logic [3:0]         col_q;
  logic [3:0]         row_s1_q, row_s2_q;
  logic [15:0]        raw_q;
  logic               frame_done_q;

  logic [15:0]        stable;
  logic [CNT_W-1:0]   match_cnt;
  logic               new_press;
  logic               press_evt;

  logic [3:0]         key_code_q;
  logic               key_valid_q;
  logic               pressed_q, multi_q, overrun_q;
  logic [4:0]         stable_pop;

  // Two-flop synchronizer; idle (pulled-up) rows read as all ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
    end else begin
      row_s1_q <= i_row;
      row_s2_q <= row_s1_q;
    end
  end

  // Column scan FSM: drive one column per SCAN_DIV cycles, sample on the last.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= COL0;
      div_q        <= '0;
      col_q        <= 4'hF;
      raw_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      col_q        <= ~(4'b0001 << state_q);
      if (div_q == DIV_LAST) begin
        div_q <= '0;
        unique case (state_q)
          COL0: begin
            raw_q[3:0] <= ~row_s2_q;
            state_q    <= COL1;
          end
          COL1: begin
            raw_q[7:4] <= ~row_s2_q;
            state_q    <= COL2;
          end
          COL2: begin
            raw_q[11:8] <= ~row_s2_q;
            state_q     <= COL3;
          end
          COL3: begin
            raw_q[15:12] <= ~row_s2_q;
            state_q      <= COL0;
            frame_done_q <= 1'b1;
          end
          default: state_q <= COL0;
        endcase
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  kypd_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_raw       (raw_q),
    .i_frame_done(frame_done_q),
    .o_stable    (stable),
    .o_match_cnt (match_cnt),
    .o_new_press (new_press)
  );

  // The press strobe is only raised on a saturated run; the extra term guards it.
  assign press_evt  = new_press && (match_cnt == CNT_LAST);
  assign stable_pop = popcount16(stable);

  // Registered key-count flags derived from the stable map.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pressed_q <= 1'b0;
      multi_q   <= 1'b0;
    end else begin
      pressed_q <= (stable_pop == 5'd1);
      multi_q   <= (stable_pop >= 5'd2);
    end
  end

  // Event register: hold until accepted; a blocked new event raises overrun.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (press_evt && key_valid_q && !kbd.key_ready) begin
        overrun_q <= 1'b1;
      end else if (i_clr_overrun) begin
        overrun_q <= 1'b0;
      end
      if (press_evt && !(key_valid_q && !kbd.key_ready)) begin
        key_code_q  <= KEY_CODE[lowest_index(stable)];
        key_valid_q <= 1'b1;
      end else if (key_valid_q && kbd.key_ready) begin
        key_valid_q <= 1'b0;
      end
    end
  end

  assign o_col         = col_q;
  assign kbd.key_code  = key_code_q;
  assign kbd.key_valid = key_valid_q;
  assign o_pressed     = pressed_q;
  assign o_multi       = multi_q;
  assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_pmod_keypad_scan.sv
// Bench for pmod_keypad_scan: keypad matrix model, scoreboard of expected key
// codes, consumer monitor that pops and compares on every accepted event.
module tb_pmod_keypad_scan;

  localparam int unsigned SCAN_DIV = 8;
  localparam int unsigned DEB      = 3;
  localparam int unsigned FRAME    = 4 * SCAN_DIV;

  logic       clk;
  logic       rst;
  logic [3:0] col;
  logic [3:0] row;
  logic       pressed, multi, overrun, clr;
  logic [15:0] keys;

  int vectors;
  int miscompares;
  int evts;
  int e0;
  int waited;
  int q_exp [$];

  pmod_keypad_scan_if kif ();

  pmod_keypad_scan #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_FRAMES(DEB)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_col        (col),
    .i_row        (row),
    .kbd          (kif),
    .o_pressed    (pressed),
    .o_multi      (multi),
    .o_overrun    (overrun),
    .i_clr_overrun(clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its row to its column when driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!col[c] && keys[4*c+r]) row[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Consumer side: every accepted event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && kif.key_valid && kif.key_ready) begin
      evts++;
      if (q_exp.size() == 0) check("sb_depth", q_exp.size(), 1);
      else check("key_code", int'(kif.key_code), q_exp.pop_front());
    end
  end

  initial begin
    vectors = 0; miscompares = 0; evts = 0;
    rst = 1'b1; keys = '0; clr = 1'b0; kif.key_ready = 1'b1;

    // Reset values
    tick(3);
    check("rst_col", int'(col), 'hF);
    check("rst_valid", int'(kif.key_valid), 0);
    check("rst_code", int'(kif.key_code), 0);
    check("rst_pressed", int'(pressed), 0);
    check("rst_multi", int'(multi), 0);
    check("rst_overrun", int'(overrun), 0);

    // Idle column scan
    rst = 1'b0;
    tick(1); check("col0", int'(col), 'hE);
    tick(8); check("col1", int'(col), 'hD);
    tick(8); check("col2", int'(col), 'hB);
    tick(8); check("col3", int'(col), 'h7);
    tick(8); check("col_wrap", int'(col), 'hE);
    tick(20 * FRAME);
    check("idle_evts", evts, 0);
    check("idle_pressed", int'(pressed), 0);

    // Key 5 held from reset, ready held low until the event shows up
    rst = 1'b1; keys = 16'h0020; kif.key_ready = 1'b0;
    tick(2);
    rst = 1'b0;
    q_exp.push_back('h5);
    waited = 0;
    while (!kif.key_valid && waited < 5 * FRAME) begin
      tick(1); waited++;
    end
    check("k5_valid", int'(kif.key_valid), 1);
    check("k5_latency_ok", int'(waited <= 4 * FRAME + 2), 1);
    check("k5_pressed", int'(pressed), 1);
    kif.key_ready = 1'b1;
    tick(1);
    kif.key_ready = 1'b0;
    check("k5_drop", int'(kif.key_valid), 0);
    kif.key_ready = 1'b1;
    tick(6 * FRAME);
    check("k5_single", evts, 1);

    // Bouncing 9, then steady
    keys = '0; tick(5 * FRAME);
    e0 = evts;
    for (int i = 0; i < 4; i++) begin
      keys[10] = ~keys[10];
      tick(40);
    end
    check("bounce_quiet", evts, e0);
    keys[10] = 1'b1;
    q_exp.push_back('h9);
    tick(6 * FRAME);
    check("bounce_one", evts, e0 + 1);

    // Two keys: multi flag, no event; then E alone
    keys = '0; tick(5 * FRAME);
    e0 = evts;
    keys = 16'h8001;
    tick(5 * FRAME);
    check("multi_flag", int'(multi), 1);
    check("multi_pressed", int'(pressed), 0);
    check("multi_noevt", evts, e0);
    keys = '0; tick(5 * FRAME);
    check("multi_clear", int'(multi), 0);
    keys = 16'h0800;
    q_exp.push_back('hE);
    tick(5 * FRAME);
    check("e_evt", evts, e0 + 1);

    // Overrun: A held pending, 3 lost
    keys = '0; tick(5 * FRAME);
    kif.key_ready = 1'b0;
    keys = 16'h1000;
    q_exp.push_back('hA);
    tick(5 * FRAME);
    check("a_valid", int'(kif.key_valid), 1);
    keys = '0; tick(5 * FRAME);
    keys = 16'h0100; tick(5 * FRAME);
    check("ovr_flag", int'(overrun), 1);
    check("ovr_code", int'(kif.key_code), 'hA);
    check("ovr_valid", int'(kif.key_valid), 1);
    clr = 1'b1; tick(1); clr = 1'b0;
    check("ovr_clr", int'(overrun), 0);
    kif.key_ready = 1'b1;
    tick(2);
    check("ovr_drain", int'(kif.key_valid), 0);
    keys = '0; tick(5 * FRAME);

    // Reset mid-frame with key 0 held
    kif.key_ready = 1'b0;
    keys = 16'h0008;
    tick(5 * FRAME);
    check("k0_valid", int'(kif.key_valid), 1);
    check("k0_code", int'(kif.key_code), 'h0);
    tick(13);
    #2 rst = 1'b1;
    #1;
    check("arst_col", int'(col), 'hF);
    check("arst_valid", int'(kif.key_valid), 0);
    check("arst_pressed", int'(pressed), 0);
    tick(2);
    rst = 1'b0;
    kif.key_ready = 1'b1;
    q_exp.push_back('h0);
    e0 = evts;
    tick(3 * FRAME - 4);
    check("k0_not_early", evts, e0);
    tick(40);
    check("k0_after_rst", evts, e0 + 1);

    check("sb_empty", q_exp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
